axi_rb_responder: RTL and testbench

AXI read-burst responder (slave end of the `s_axi_ar*`/`s_axi_r*` read channel driven by the team's read-burst initiators). It accepts one address-phase request at a time, reads consecutive words from a synchronous single-port memory, and returns them as R beats with full backpressure support. It sits between the HLS-generated initiator and an on-chip word RAM; the write channels are out of scope.

---
 rtl/axi_rb_pkg.sv | 27 ++
 rtl/axi_rb_skid.sv | 68 ++++++
 rtl/axi_rb_responder.sv | 142 ++++++++++++++
 tb/tb_axi_rb_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rb_pkg.sv
// Shared types and constants for the AXI read-burst responder.
package axi_rb_pkg;

  localparam int unsigned DataW       = 32;
  localparam int unsigned MaxBeats    = 256;
  localparam int unsigned CreditDepth = 2;
  localparam int unsigned CntW        = $clog2(MaxBeats) + 1;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2,
    BurstRsvd  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDrain
  } state_e;

  // Sizes above one word clamp to a 4-byte step.
  function automatic logic [2:0] byte_incr(input logic [2:0] size);
    return (size >= 3'd2) ? 3'd4 : (3'd1 << size);
  endfunction

endpackage

// File: rtl/axi_rb_skid.sv
// Two-entry valid/ready buffer; an empty buffer forwards the pushed word straight to the head.
module axi_rb_skid #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] buf_q [2];
  logic [Width-1:0] buf_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop, store, deq;

  assign valid_o = (count_q != 2'd0) || push_i;
  assign count_o = count_q;
  assign pop     = valid_o && ready_i;
  // A push that is consumed in the same cycle it arrives never occupies an entry.
  assign store   = push_i && !(pop && (count_q == 2'd0));
  assign deq     = pop && (count_q != 2'd0);

  always_comb begin
    if (count_q != 2'd0) begin
      data_o = buf_q[rd_ptr_q];
    end else if (push_i) begin
      data_o = push_data_i;
    end else begin
      data_o = '0;
    end
  end

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      buf_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, store} - {1'b0, deq};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_rb_responder.sv
// AXI read-burst responder: one burst at a time from a synchronous word RAM, credit-limited to 2.
// Optional AXI_RB_RLAST_EN adds s_axi_rlast marking the final beat of each burst.
module axi_rb_responder
  import axi_rb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
`ifdef AXI_RB_RLAST_EN
  output logic              s_axi_rlast,
`endif
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [MEM_AW-1:0] mem_raddr,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        incr_q, incr_d;
  logic              fixed_q, fixed_d;
  logic [CntW-1:0]   beats_q, beats_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   done_q, done_d;
  logic              inflight_q;
  logic [1:0]        skid_count;
  logic [2:0]        occupancy;
  logic              issue, pop, last_issue;

`ifdef AXI_RB_RLAST_EN
  localparam int unsigned SkidW = DataW + 1;
  logic             last_q;
  logic [SkidW-1:0] skid_in, skid_out;
  assign skid_in     = {last_q, mem_rdata};
  assign s_axi_rdata = skid_out[DataW-1:0];
  assign s_axi_rlast = skid_out[DataW];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= issue && last_issue;
    end
  end
`else
  localparam int unsigned SkidW = DataW;
  logic [SkidW-1:0] skid_in, skid_out;
  assign skid_in     = mem_rdata;
  assign s_axi_rdata = skid_out;
`endif

  axi_rb_skid #(
    .Width (SkidW)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (inflight_q),
    .push_data_i (skid_in),
    .ready_i     (s_axi_rready),
    .valid_o     (s_axi_rvalid),
    .data_o      (skid_out),
    .count_o     (skid_count)
  );

  assign pop           = s_axi_rvalid && s_axi_rready;
  // A beat leaving this cycle frees its credit for an issue in the same cycle.
  assign occupancy     = {1'b0, skid_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign last_issue    = (issued_q + CntW'(1)) == beats_q;
  assign issue         = (state_q == StBurst) && (issued_q < beats_q) &&
                         (occupancy < 3'(CreditDepth)) && !rst;
  assign mem_ren       = issue;
  assign mem_raddr     = addr_q[MEM_AW+1:2];
  assign s_axi_arready = (state_q == StIdle) && !rst;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    incr_d   = incr_q;
    fixed_d  = fixed_q;
    beats_d  = beats_q;
    issued_d = issued_q;
    done_d   = done_q;
    unique case (state_q)
      StIdle: begin
        if (s_axi_arvalid && s_axi_arready) begin
          addr_d   = s_axi_araddr;
          incr_d   = byte_incr(s_axi_arsize);
          fixed_d  = burst_e'(s_axi_arburst) == BurstFixed;
          beats_d  = {1'b0, s_axi_arlen} + CntW'(1);
          issued_d = '0;
          done_d   = '0;
          state_d  = StBurst;
        end
      end
      StBurst: begin
        if (issue && last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (pop && ((done_q + CntW'(1)) == beats_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      issued_d = issued_q + CntW'(1);
      if (!fixed_q) addr_d = addr_q + ADDR_W'(incr_q);
    end
    if (pop) done_d = done_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      incr_q     <= 3'd4;
      fixed_q    <= 1'b0;
      beats_q    <= '0;
      issued_q   <= '0;
      done_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      incr_q     <= incr_d;
      fixed_q    <= fixed_d;
      beats_q    <= beats_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      inflight_q <= issue;
    end
  end

endmodule

// File: tb/tb_axi_rb_responder.sv
// Directed bench for axi_rb_responder with a scoreboard of expected R beats.
module tb_axi_rb_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [7:0]  mem_raddr;
  logic        mem_ren;
  logic [31:0] mem_rdata;
`ifdef AXI_RB_RLAST_EN
  logic        rlast;
`endif

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int popped = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  always #5 clk = ~clk;

  axi_rb_responder #(
    .ADDR_W (16),
    .MEM_AW (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
`ifdef AXI_RB_RLAST_EN
    .s_axi_rlast   (rlast),
`endif
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .mem_raddr     (mem_raddr),
    .mem_ren       (mem_ren),
    .mem_rdata     (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent address model: builds the beat list the burst should return.
  task automatic push_burst(input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int unsigned b;
    int unsigned inc;
    int unsigned w;
    b   = addr;
    inc = (size > 3'd2) ? 4 : (1 << size);
    for (int i = 0; i <= int'(len); i++) begin
      w = (b >> 2) % 256;
      exp_q.push_back('{data: mem[w], last: (i == int'(len))});
      if (burst != 2'd0) b = (b + inc) % 65536;
    end
  endtask

  // Monitor: scoreboard compare, stall stability and outstanding-read bound.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      issued     = 0;
      popped     = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(rvalid), 32'd1);
        check("stall_data", rdata, stall_data);
      end
      if (mem_ren) issued++;
      if (rvalid && rready) begin
        popped++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", rdata, e.data);
`ifdef AXI_RB_RLAST_EN
          check("rlast", 32'(rlast), 32'(e.last));
`endif
        end
      end
      if (mem_ren) check("credit_le2", 32'(issued - popped <= 2), 32'd1);
      stall_prev = rvalid && !rready;
      stall_data = rdata;
    end
  end

  task automatic do_req(input logic [15:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    push_burst(addr, len, size, burst);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("ar_timeout", 32'(ok), 32'd1);
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (toggle) rready = ~rready;
      @(negedge clk);
      if (exp_q.size() == 0 && arready) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_done", 32'(ok), 32'd1);
    rready = 1'b1;
  endtask

  initial begin
    int base;
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 32'(k * 32'h11);
    rst     = 1'b1;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'(arready), 32'd1);

    // Basic INCR burst with cycle-accurate latency checks.
    base = popped;
    do_req(16'h0010, 8'd3, 3'd2, 2'd1);
    @(negedge clk);
    check("t1_rvalid", 32'(rvalid), 32'd0);
    check("t1_mem_ren", 32'(mem_ren), 32'd1);
    check("t1_raddr", 32'(mem_raddr), 32'd4);
    @(negedge clk);
    check("t2_rvalid", 32'(rvalid), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_arready", 32'(arready), 32'd0);
    @(negedge clk);
    check("t6_arready", 32'(arready), 32'd1);
    check("t6_beats", 32'(popped - base), 32'd4);
    check("t6_empty", 32'(exp_q.size()), 32'd0);

    // Same request under toggling backpressure.
    do_req(16'h0010, 8'd3, 3'd2, 2'd1);
    wait_done(1'b1);

    // FIXED bursts.
    do_req(16'h0008, 8'd0, 3'd2, 2'd0);
    wait_done(1'b0);
    do_req(16'h0008, 8'd2, 3'd2, 2'd0);
    wait_done(1'b1);

    // Word-address wrap.
    do_req(16'h03FC, 8'd1, 3'd2, 2'd1);
    wait_done(1'b0);

    // Sub-word and oversize beats.
    do_req(16'h0000, 8'd3, 3'd1, 2'd1);
    wait_done(1'b0);
    do_req(16'h0010, 8'd3, 3'd5, 2'd1);
    wait_done(1'b0);
    do_req(16'h0021, 8'd5, 3'd0, 2'd2);
    wait_done(1'b1);

    // Reset in the middle of an 8-beat burst.
    base = popped;
    ok   = 1'b0;
    do_req(16'h0040, 8'd7, 3'd2, 2'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (popped - base >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_burst_progress", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_mem_ren", 32'(mem_ren), 32'd0);
    check("mid_rst_raddr", 32'(mem_raddr), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("no_partial_beat", 32'(rvalid), 32'd0);
    end
    do_req(16'h0020, 8'd1, 3'd2, 2'd1);
    wait_done(1'b0);
    do_req(16'h0100, 8'd4, 3'd2, 2'd3);
    wait_done(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
